// File: rtl/floppy_arb_pkg.sv
// ============================================================================
// Module   : floppy_arb_pkg
// Desc     : Shared state encoding and default sizes for the floppy SD arbiter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package floppy_arb_pkg;

  localparam int c_nreq_default  = 2;
  localparam int c_lba_w_default = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_XFER  = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Desc     : Round-robin pick, searching upward from the slot after last owner.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import floppy_arb_pkg::*;
#(
  parameter int NREQ = c_nreq_default,
  parameter int ID_W = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] last,
  output logic [NREQ-1:0] grant,
  output logic            valid
);

  // Offset 1 is checked first so the previous owner is considered last.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!valid && req[j] && (j == (int'(last) + off) % NREQ)) begin
          grant[j] = 1'b1;
          valid    = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/floppy_sd_arbiter.sv
// ============================================================================
// Module   : floppy_sd_arbiter
// Desc     : Shares one SD host block channel among floppy track buffers.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module floppy_sd_arbiter
  import floppy_arb_pkg::*;
#(
  parameter int  NREQ   = c_nreq_default,
  parameter int  LBA_W  = c_lba_w_default,
  localparam int c_id_w = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0][LBA_W-1:0] req_lba,
  input  logic [NREQ-1:0]            req_rd,
  input  logic [NREQ-1:0]            req_wr,
  output logic [NREQ-1:0]            req_ack,
  input  logic [NREQ-1:0][7:0]       req_buff_din,
  output logic [NREQ-1:0]            req_buff_wr,
  output logic [LBA_W-1:0]           sd_lba,
  output logic                       sd_rd,
  output logic                       sd_wr,
  input  logic                       sd_ack,
  input  logic                       sd_buff_wr,
  output logic [7:0]                 sd_buff_din,
  output logic [c_id_w-1:0]          grant_id,
  output logic                       busy
);

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic [LBA_W-1:0]   r_lba;
  logic [c_id_w-1:0]  r_grant;
  logic               r_dir_wr;

  logic [NREQ-1:0]    w_req;
  logic [NREQ-1:0]    w_rr_grant;
  logic               w_rr_valid;
  logic [c_id_w-1:0]  w_win_id;
  logic [LBA_W-1:0]   w_win_lba;
  logic               w_win_wr;
  logic               w_take;

  assign w_req = req_rd | req_wr;

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (c_id_w)
  ) u_rr (
    .req   (w_req),
    .last  (r_grant),
    .grant (w_rr_grant),
    .valid (w_rr_valid)
  );

  // Write beats read when the winner holds both; the read stays pending.
  always_comb begin
    w_win_id  = '0;
    w_win_lba = '0;
    w_win_wr  = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (w_rr_grant[j]) begin
        w_win_id  = c_id_w'(j);
        w_win_lba = req_lba[j];
        w_win_wr  = req_wr[j];
      end
    end
  end

  assign w_take = (r_state == ST_IDLE) && w_rr_valid;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= ST_DRAIN;
      r_lba    <= '0;
      r_grant  <= c_id_w'(NREQ - 1);
      r_dir_wr <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take) begin
        r_lba    <= w_win_lba;
        r_grant  <= w_win_id;
        r_dir_wr <= w_win_wr;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    sd_rd       = 1'b0;
    sd_wr       = 1'b0;
    busy        = 1'b0;
    req_ack     = '0;
    req_buff_wr = '0;
    case (r_state)
      ST_IDLE:  if (w_rr_valid) w_state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        sd_rd = !r_dir_wr;
        sd_wr = r_dir_wr;
        busy  = 1'b1;
        if (sd_ack) w_state_nxt = ST_XFER;
      end
      ST_XFER: begin
        busy = 1'b1;
        for (int j = 0; j < NREQ; j++) begin
          if (r_grant == c_id_w'(j)) begin
            req_ack[j]     = sd_ack;
            req_buff_wr[j] = sd_buff_wr & sd_ack;
          end
        end
        if (!sd_ack) w_state_nxt = ST_IDLE;
      end
      ST_DRAIN: if (!sd_ack) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_DRAIN;
    endcase
    // Reset silences the host-facing strobes before the next edge lands.
    if (!reset) begin
      sd_rd       = 1'b0;
      sd_wr       = 1'b0;
      busy        = 1'b0;
      req_ack     = '0;
      req_buff_wr = '0;
    end
  end

  assign sd_lba      = r_lba;
  assign grant_id    = r_grant;
  assign sd_buff_din = req_buff_din[r_grant];

endmodule

`default_nettype wire
